// File: rtl/temp_datapath.sv
// Temperature window datapath: accumulates N samples on hab and, on arm, registers
// the window average, the window maximum and an over-limit alert.
module temp_datapath #(
  parameter int DATA_W = 8,
  parameter int LOG2_N = 3,
  parameter int LIMITE = 80
) (
  input  logic              clk_controle,
  input  logic              reset,
  input  logic              limp,
  input  logic              hab,
  input  logic              arm,
  input  logic [DATA_W-1:0] temp_in,
  output logic [DATA_W-1:0] media,
  output logic [DATA_W-1:0] temp_max,
  output logic              alerta,
  output logic              valido,
  output logic              erro,
  output logic [LOG2_N:0]   cont,
  output logic              cheio
);

  localparam int ACC_W = DATA_W + LOG2_N;
  localparam int CNT_W = LOG2_N + 1;
  localparam logic [CNT_W-1:0] N   = CNT_W'(1 << LOG2_N);
  localparam logic [DATA_W:0]  LIM = (DATA_W + 1)'(LIMITE);

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] max_p_q, max_p_d;
  logic [DATA_W-1:0] media_q, media_d;
  logic [DATA_W-1:0] temp_max_q, temp_max_d;
  logic              alerta_q, alerta_d;
  logic              valido_q, valido_d;
  logic              erro_q, erro_d;

  logic              full;
  logic [DATA_W-1:0] window_avg;

  assign full       = (cnt_q == N);
  assign window_avg = acc_q[ACC_W-1:LOG2_N];

  always_comb begin
    // NOTE: every signal gets a default before the priority chain, so no path
    // through it can leave a value unassigned and infer a latch.
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    max_p_d    = max_p_q;
    media_d    = media_q;
    temp_max_d = temp_max_q;
    alerta_d   = alerta_q;
    valido_d   = 1'b0;
    erro_d     = 1'b0;

    // Priority limp > arm > hab; a lower strobe in the same cycle is dropped.
    if (limp) begin
      acc_d   = '0;
      cnt_d   = '0;
      max_p_d = '0;
    end else if (arm) begin
      if (full) begin
        media_d    = window_avg;
        temp_max_d = max_p_q;
        alerta_d   = ({1'b0, window_avg} >= LIM);
        valido_d   = 1'b1;
      end else begin
        erro_d = 1'b1;
      end
    end else if (hab && !full) begin
      acc_d   = acc_q + ACC_W'(temp_in);
      cnt_d   = cnt_q + 1'b1;
      max_p_d = (temp_in > max_p_q) ? temp_in : max_p_q;
    end
  end

  always_ff @(posedge clk_controle) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    if (reset) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      max_p_q    <= '0;
      media_q    <= '0;
      temp_max_q <= '0;
      alerta_q   <= 1'b0;
      valido_q   <= 1'b0;
      erro_q     <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      max_p_q    <= max_p_d;
      media_q    <= media_d;
      temp_max_q <= temp_max_d;
      alerta_q   <= alerta_d;
      valido_q   <= valido_d;
      erro_q     <= erro_d;
    end
  end

  assign media    = media_q;
  assign temp_max = temp_max_q;
  assign alerta   = alerta_q;
  assign valido   = valido_q;
  assign erro     = erro_q;
  assign cont     = cnt_q;
  assign cheio    = full;

endmodule
